ref_line_feeder: RTL and testbench

Upstream feeder for the reference-strip SRAM stage. It buffers 64-bit reference words (8 pixels, one row of one 8-pixel column strip) from the external fetch path in a FIFO. Once enough data is banked, it issues the one-cycle `next_line` restart. It then streams exactly one word per clock into the SRAM stage's `ref_in`, matching that stage's fixed write rate of one word per cycle, 23 rows per strip, with no stall input.

---
 rtl/me_ref_pkg.sv | 13 +
 rtl/ref_word_fifo.sv | 61 ++++++
 rtl/ref_line_feeder.sv | 115 +++++++++++
 tb/tb_ref_line_feeder.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/me_ref_pkg.sv
// Shared definitions for the reference-strip feed path into the SRAM stage.
package me_ref_pkg;
  localparam int PIX_W      = 8;
  localparam int WORD_PIX   = 8;
  localparam int SRAM_ROWS  = 23;
  localparam int REF_WORD_W = PIX_W * WORD_PIX;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    PRIME  = 2'd1,
    STREAM = 2'd2
  } feed_state_e;
endpackage

// File: rtl/ref_word_fifo.sv
// Synchronous FIFO of reference words with a binary occupancy count.
module ref_word_fifo
  import me_ref_pkg::*;
#(
  parameter int DEPTH = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    push,
  input  logic [REF_WORD_W-1:0]   push_data,
  input  logic                    pop,
  output logic [REF_WORD_W-1:0]   head_data,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    full,
  output logic                    empty
);
  localparam int AW = $clog2(DEPTH);

  logic [REF_WORD_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [AW:0]           count_q, count_d;
  logic                  push_ok, pop_ok;

  assign full      = (count_q == (AW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign count     = count_q;
  assign head_data = mem_q[rd_ptr_q];

  always_comb begin
    push_ok  = push && !full;
    pop_ok   = pop && !empty;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + AW'(1);
    if (pop_ok)  rd_ptr_d = rd_ptr_q + AW'(1);
    // pointers wrap naturally because DEPTH is a power of two
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_ptr_q] <= push_data;
  end
endmodule

// File: rtl/ref_line_feeder.sv
// Banks reference words, then streams one line of words per clock into the SRAM stage.
// state  | meaning
// IDLE   | waiting for line_start
// PRIME  | waiting for FIFO occupancy to reach PRIME_LEVEL
// STREAM | popping one word per clock until the line is complete
module ref_line_feeder
  import me_ref_pkg::*;
#(
  parameter int DEPTH       = 32,
  parameter int PRIME_LEVEL = 23,
  parameter int LINE_WORDS  = 368
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        line_start,
  input  logic [63:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [63:0] ref_in,
  output logic        next_line,
  output logic        busy,
  output logic        underrun,
  output logic [4:0]  row_phase
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int WW = $clog2(LINE_WORDS);

  feed_state_e   state_q, state_d;
  logic [WW-1:0] words_left_q, words_left_d;
  logic [63:0]   ref_in_q, ref_in_d;
  logic          next_line_q, next_line_d;
  logic          underrun_q, underrun_d;
  logic [4:0]    row_phase_q, row_phase_d;

  logic          push, pop;
  logic [63:0]   head;
  logic [CW-1:0] count;
  logic          full, empty;

  assign in_ready  = !full;
  assign push      = in_valid && in_ready;
  assign busy      = (state_q != IDLE);
  assign ref_in    = ref_in_q;
  assign next_line = next_line_q;
  assign underrun  = underrun_q;
  assign row_phase = row_phase_q;

  ref_word_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (in_data),
    .pop       (pop),
    .head_data (head),
    .count     (count),
    .full      (full),
    .empty     (empty)
  );

  always_comb begin
    state_d      = state_q;
    words_left_d = words_left_q;
    ref_in_d     = '0;
    next_line_d  = 1'b0;
    underrun_d   = underrun_q;
    row_phase_d  = row_phase_q;
    pop          = 1'b0;
    case (state_q)
      IDLE: begin
        if (line_start) begin
          state_d      = PRIME;
          words_left_d = WW'(LINE_WORDS - 1);
          underrun_d   = 1'b0;
        end
      end
      PRIME: begin
        if (count >= CW'(PRIME_LEVEL)) begin
          state_d     = STREAM;
          next_line_d = 1'b1;
        end
      end
      STREAM: begin
        // the SRAM stage cannot stall, so an empty pop still consumes a slot
        pop      = 1'b1;
        ref_in_d = empty ? '0 : head;
        if (empty) underrun_d = 1'b1;
        if (words_left_q == WW'(LINE_WORDS - 1) || row_phase_q == 5'(SRAM_ROWS - 1))
          row_phase_d = '0;
        else
          row_phase_d = row_phase_q + 5'd1;
        words_left_d = words_left_q - WW'(1);
        if (words_left_q == '0) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      words_left_q <= '0;
      ref_in_q     <= '0;
      next_line_q  <= 1'b0;
      underrun_q   <= 1'b0;
      row_phase_q  <= '0;
    end else begin
      state_q      <= state_d;
      words_left_q <= words_left_d;
      ref_in_q     <= ref_in_d;
      next_line_q  <= next_line_d;
      underrun_q   <= underrun_d;
      row_phase_q  <= row_phase_d;
    end
  end
endmodule

// File: tb/tb_ref_line_feeder.sv
// Randomized bench for ref_line_feeder against a queue-based line model.
module tb_ref_line_feeder;
  localparam int DEPTH       = 32;
  localparam int PRIME_LEVEL = 23;
  localparam int LINE_WORDS  = 368;
  localparam int ROWS        = 23;

  logic        clk = 1'b0;
  logic        rst;
  logic        line_start;
  logic [63:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] ref_in;
  logic        next_line;
  logic        busy;
  logic        underrun;
  logic [4:0]  row_phase;

  int vectors     = 0;
  int miscompares = 0;

  // model: 0 idle, 1 waiting for data, 2 streaming
  logic [63:0] q[$];
  int          mode;
  int          pops;
  logic [63:0] m_ref;
  logic        m_nl;
  logic        m_ur;
  logic [4:0]  m_row;
  logic        seq_mode;
  logic [63:0] seq_val;
  logic [63:0] cur_word;

  always #5 clk = ~clk;

  ref_line_feeder #(.DEPTH(DEPTH), .PRIME_LEVEL(PRIME_LEVEL), .LINE_WORDS(LINE_WORDS)) dut (
    .clk        (clk),
    .rst        (rst),
    .line_start (line_start),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .ref_in     (ref_in),
    .next_line  (next_line),
    .busy       (busy),
    .underrun   (underrun),
    .row_phase  (row_phase)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    check("ref_in", ref_in, m_ref);
    check("next_line", {63'd0, next_line}, {63'd0, m_nl});
    check("busy", {63'd0, busy}, {63'd0, (mode != 0)});
    check("underrun", {63'd0, underrun}, {63'd0, m_ur});
    check("row_phase", {59'd0, row_phase}, {59'd0, m_row});
    check("in_ready", {63'd0, in_ready}, {63'd0, (q.size() < DEPTH)});
  endtask

  task automatic model_reset();
    q.delete();
    mode  = 0;
    pops  = 0;
    m_ref = '0;
    m_nl  = 1'b0;
    m_ur  = 1'b0;
    m_row = '0;
  endtask

  task automatic new_word();
    cur_word = seq_mode ? seq_val : {$urandom, $urandom};
  endtask

  // called at the falling edge; returns at the next falling edge
  task automatic cycle(input logic v, input logic ls);
    int   cnt;
    logic push;
    in_valid   = v;
    line_start = ls;
    in_data    = cur_word;
    cnt  = q.size();
    push = v && (cnt < DEPTH);
    m_nl  = 1'b0;
    m_ref = '0;
    if (mode == 2) begin
      if (cnt > 0) m_ref = q.pop_front();
      else m_ur = 1'b1;
      m_row = 5'(pops % ROWS);
      pops++;
      if (pops == LINE_WORDS) mode = 0;
    end else if (mode == 1) begin
      if (cnt >= PRIME_LEVEL) begin
        mode = 2;
        m_nl = 1'b1;
      end
    end else if (ls) begin
      mode = 1;
      pops = 0;
      m_ur = 1'b0;
    end
    if (push) q.push_back(cur_word);
    @(posedge clk);
    #1;
    check_all();
    if (push) begin
      if (seq_mode) seq_val++;
      new_word();
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst        = 1'b1;
    in_valid   = 1'b0;
    line_start = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_until_idle(input int pct, input int ls_at, input int rst_at, input int starve_at);
    logic v;
    for (int i = 0; i < 2000 && mode != 0; i++) begin
      v = ($urandom_range(0, 99) < pct);
      if (starve_at >= 0 && pops >= starve_at && pops < starve_at + 30) v = 1'b0;
      if (rst_at >= 0 && mode == 2 && pops == rst_at) begin
        do_reset();
        return;
      end
      cycle(v, (ls_at >= 0 && mode == 2 && pops == ls_at));
    end
    check("line_end_busy", {63'd0, busy}, 64'd0);
  endtask

  initial begin
    rst        = 1'b1;
    line_start = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    seq_mode   = 1'b1;
    seq_val    = 64'd1;
    model_reset();
    new_word();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    rst = 1'b0;

    // prefill 1..23, start a line, keep feeding sequential words
    repeat (PRIME_LEVEL) cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);
    run_until_idle(100, -1, -1, -1);

    // fill against an idle consumer until in_ready drops
    seq_mode = 1'b0;
    new_word();
    repeat (40) cycle(1'b1, 1'b0);

    // starve the stream for 30 words after priming
    cycle(1'b0, 1'b1);
    run_until_idle(100, -1, -1, 40);

    // next line clears underrun; line_start mid-stream is ignored
    cycle(1'b1, 1'b1);
    run_until_idle(70, 50, -1, -1);
    repeat (3) cycle(1'b0, 1'b1);
    run_until_idle(90, 200, -1, -1);

    // reset at word 100
    cycle(1'b1, 1'b1);
    run_until_idle(100, -1, 100, -1);

    // empty FIFO, one word every third cycle while priming
    cycle(1'b0, 1'b1);
    for (int i = 0; i < 200 && mode == 1; i++) cycle((i % 3) == 0, 1'b0);
    run_until_idle(100, -1, -1, -1);
    repeat (5) cycle(1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
